dino_sprite_fsm: RTL and testbench

Parametrised successor to the dino movement-select FSM. Replaces the external animation clock with an internal tick-driven frame sequencer. Supports configurable run/duck cycle lengths, a death-flash sequence and a restart path. Sits between the game-state logic (jump/collision/pause) and the sprite ROM address mux; drives the sprite select each cycle.

---
 rtl/dino_sprite_fsm.sv | 150 +++++++++++++++
 tb/tb_dino_sprite_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dino_sprite_fsm.sv
// Dino sprite sequencer: picks the sprite code each cycle from game-state inputs,
// with a tick-driven frame divider for run/duck cycles and a death-flash sequence.
module dino_sprite_fsm #(
   parameter int SEL_W       = 4,
   parameter int RUN_FRAMES  = 2,
   parameter int DUCK_FRAMES = 2,
   parameter int FRAME_DIV   = 6,
   parameter int DEAD_FLASH  = 4,
   parameter int SPR_STAND   = 0,
   parameter int SPR_DEAD    = 1,
   parameter int SPR_BLANK   = 2,
   parameter int RUN_BASE    = 4,
   parameter int DUCK_BASE   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             Airborne,
   input  logic             onGround,
   input  logic             isDuck,
   input  logic             isDead,
   input  logic             isPaused,
   input  logic             restart,
   output logic [SEL_W-1:0] DinoMovementSelect,
   output logic [2:0]       frameIdx,
   output logic [2:0]       dinoState
);

   typedef enum logic [2:0] {
      ST_STAND = 3'd0,
      ST_RUN   = 3'd1,
      ST_DUCK  = 3'd2,
      ST_JUMP  = 3'd3,
      ST_PAUSE = 3'd4,
      ST_FLASH = 3'd5,
      ST_DEAD  = 3'd6
   } state_t;

   localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int FL_W  = (DEAD_FLASH > 2) ? $clog2(DEAD_FLASH) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAME_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
   localparam logic [FL_W-1:0]  FL_LAST   = FL_W'((DEAD_FLASH > 0) ? DEAD_FLASH - 1 : 0);
   localparam logic [FL_W-1:0]  FL_ONE    = FL_W'(1);
   localparam logic [2:0]       RUN_LAST  = 3'(RUN_FRAMES - 1);
   localparam logic [2:0]       DUCK_LAST = 3'(DUCK_FRAMES - 1);

   localparam logic [SEL_W-1:0] S_STAND = SEL_W'(SPR_STAND);
   localparam logic [SEL_W-1:0] S_DEAD  = SEL_W'(SPR_DEAD);
   localparam logic [SEL_W-1:0] S_BLANK = SEL_W'(SPR_BLANK);
   localparam logic [SEL_W-1:0] S_RUN   = SEL_W'(RUN_BASE);
   localparam logic [SEL_W-1:0] S_DUCK  = SEL_W'(DUCK_BASE);

   // With no flash configured a collision lands straight in DEAD.
   localparam state_t DEATH_ST = (DEAD_FLASH == 0) ? ST_DEAD : ST_FLASH;

   if ((RUN_BASE + RUN_FRAMES - 1) >= (1 << SEL_W)) begin : g_run_range
      $error("dino_sprite_fsm: run sprite codes do not fit in SEL_W bits");
   end
   if ((DUCK_BASE + DUCK_FRAMES - 1) >= (1 << SEL_W)) begin : g_duck_range
      $error("dino_sprite_fsm: duck sprite codes do not fit in SEL_W bits");
   end

   state_t           r_state;
   logic [DIV_W-1:0] r_div;
   logic [2:0]       r_frame;
   logic [FL_W-1:0]  r_flash_cnt;
   logic             r_flash_ph;
   logic [SEL_W-1:0] r_sel;

   state_t           w_next_state;
   logic             w_wrap;
   logic [DIV_W-1:0] w_next_div;
   logic [2:0]       w_next_frame;
   logic [FL_W-1:0]  w_next_cnt;
   logic             w_next_ph;
   logic [SEL_W-1:0] w_next_sel;

   always_comb begin
      w_wrap       = tick && (r_div == DIV_LAST);
      w_next_state = r_state;
      case (r_state)
         ST_FLASH: begin
            if (restart && !isDead)                       w_next_state = ST_STAND;
            else if (w_wrap && (r_flash_cnt == FL_LAST))  w_next_state = ST_DEAD;
         end
         ST_DEAD: begin
            if (restart && !isDead) w_next_state = ST_STAND;
         end
         default: begin
            if (isDead)        w_next_state = DEATH_ST;
            else if (Airborne) w_next_state = ST_JUMP;
            else if (isPaused) w_next_state = ST_PAUSE;
            else if (onGround) w_next_state = isDuck ? ST_DUCK : ST_RUN;
            else               w_next_state = ST_STAND;
         end
      endcase

      // Counters restart on any state change, which also swallows a coincident tick.
      w_next_div   = '0;
      w_next_frame = 3'd0;
      w_next_cnt   = '0;
      w_next_ph    = 1'b0;
      if (w_next_state == r_state) begin
         if ((r_state == ST_RUN) || (r_state == ST_DUCK) || (r_state == ST_FLASH))
            w_next_div = tick ? (w_wrap ? '0 : r_div + DIV_ONE) : r_div;
         case (r_state)
            ST_RUN:   w_next_frame = w_wrap ? ((r_frame == RUN_LAST) ? 3'd0 : r_frame + 3'd1) : r_frame;
            ST_DUCK:  w_next_frame = w_wrap ? ((r_frame == DUCK_LAST) ? 3'd0 : r_frame + 3'd1) : r_frame;
            ST_FLASH: begin
               w_next_cnt = w_wrap ? r_flash_cnt + FL_ONE : r_flash_cnt;
               w_next_ph  = w_wrap ? ~r_flash_ph : r_flash_ph;
            end
            default: ;
         endcase
      end

      case (w_next_state)
         ST_RUN:   w_next_sel = S_RUN + SEL_W'(w_next_frame);
         ST_DUCK:  w_next_sel = S_DUCK + SEL_W'(w_next_frame);
         ST_FLASH: w_next_sel = w_next_ph ? S_BLANK : S_DEAD;
         ST_DEAD:  w_next_sel = S_DEAD;
         default:  w_next_sel = S_STAND;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_STAND;
         r_div       <= '0;
         r_frame     <= 3'd0;
         r_flash_cnt <= '0;
         r_flash_ph  <= 1'b0;
         r_sel       <= S_STAND;
      end else begin
         r_state     <= w_next_state;
         r_div       <= w_next_div;
         r_frame     <= w_next_frame;
         r_flash_cnt <= w_next_cnt;
         r_flash_ph  <= w_next_ph;
         r_sel       <= w_next_sel;
      end
   end

   assign DinoMovementSelect = r_sel;
   assign frameIdx           = r_frame;
   assign dinoState          = r_state;

endmodule

// File: tb/tb_dino_sprite_fsm.sv
// Directed bench for dino_sprite_fsm: default-parameter instance driven from a vector
// table and hand sequences, plus a second instance with a short run cycle and no flash.
module tb_dino_sprite_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       Airborne = 1'b0;
   logic       onGround = 1'b0;
   logic       isDuck = 1'b0;
   logic       isDead = 1'b0;
   logic       isPaused = 1'b0;
   logic       restart = 1'b0;
   logic [3:0] sel;
   logic [2:0] frm;
   logic [2:0] st;
   logic [3:0] p_sel;
   logic [2:0] p_frm;
   logic [2:0] p_st;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dino_sprite_fsm dut (
      .clk(clk), .rst(rst), .tick(tick), .Airborne(Airborne), .onGround(onGround),
      .isDuck(isDuck), .isDead(isDead), .isPaused(isPaused), .restart(restart),
      .DinoMovementSelect(sel), .frameIdx(frm), .dinoState(st)
   );

   dino_sprite_fsm #(.RUN_FRAMES(3), .FRAME_DIV(1), .DEAD_FLASH(0)) dut_p (
      .clk(clk), .rst(rst), .tick(tick), .Airborne(Airborne), .onGround(onGround),
      .isDuck(isDuck), .isDead(isDead), .isPaused(isPaused), .restart(restart),
      .DinoMovementSelect(p_sel), .frameIdx(p_frm), .dinoState(p_st)
   );

   // Input bits, MSB first: rst, tick, Airborne, onGround, isDuck, isDead, isPaused, restart.
   typedef struct {
      logic [7:0] in;
      int         sel;
      int         frm;
      int         st;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [7:0] in, input int s, input int f, input int t);
      vec_t v;
      v.in  = in;
      v.sel = s;
      v.frm = f;
      v.st  = t;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input int s, input int f, input int t);
      chk({name, ".sel"}, 32'(sel), 32'(s));
      chk({name, ".frame"}, 32'(frm), 32'(f));
      chk({name, ".state"}, 32'(st), 32'(t));
   endtask

   task automatic set_in(input logic [7:0] in);
      {rst, tick, Airborne, onGround, isDuck, isDead, isPaused, restart} = in;
   endtask

   task automatic do_reset();
      set_in(8'b0000_0000);
      repeat (2) step();
      rst = 1'b1;
   endtask

   initial begin
      // Reset with every input high, then run animation, priority and pause/resume.
      tbl.push_back(mk(8'b0111_1111, 0, 0, 0));
      tbl.push_back(mk(8'b0111_1111, 0, 0, 0));
      tbl.push_back(mk(8'b1001_0000, 4, 0, 1));
      tbl.push_back(mk(8'b1101_0000, 4, 0, 1));
      tbl.push_back(mk(8'b1001_0000, 4, 0, 1));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(8'b1101_0000, 4, 0, 1));
      tbl.push_back(mk(8'b1101_0000, 5, 1, 1));
      tbl.push_back(mk(8'b1001_0000, 5, 1, 1));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(8'b1101_0000, 5, 1, 1));
      tbl.push_back(mk(8'b1101_0000, 4, 0, 1));
      tbl.push_back(mk(8'b1011_0010, 0, 0, 3));
      tbl.push_back(mk(8'b1001_0000, 4, 0, 1));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(8'b1101_0000, 4, 0, 1));
      tbl.push_back(mk(8'b1101_0000, 5, 1, 1));
      tbl.push_back(mk(8'b1001_0010, 0, 0, 4));
      tbl.push_back(mk(8'b1101_0010, 0, 0, 4));
      tbl.push_back(mk(8'b1001_0000, 4, 0, 1));
      tbl.push_back(mk(8'b1101_0000, 4, 0, 1));
      tbl.push_back(mk(8'b1001_0001, 4, 0, 1));
      tbl.push_back(mk(8'b1000_0000, 0, 0, 0));
      tbl.push_back(mk(8'b1101_0000, 4, 0, 1));
      for (int i = 0; i < 5; i++) tbl.push_back(mk(8'b1101_0000, 4, 0, 1));
      tbl.push_back(mk(8'b1101_0000, 5, 1, 1));

      foreach (tbl[i]) begin
         set_in(tbl[i].in);
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].sel, tbl[i].frm, tbl[i].st);
      end

      // Duck switch mid-frame clears the divider.
      do_reset();
      chk_all("reset2", 0, 0, 0);
      onGround = 1'b1;
      step();
      chk_all("run_enter", 4, 0, 1);
      tick = 1'b1;
      repeat (3) step();
      tick = 1'b0;
      isDuck = 1'b1;
      step();
      chk_all("duck_enter", 8, 0, 2);
      tick = 1'b1;
      repeat (5) step();
      chk_all("duck_5ticks", 8, 0, 2);
      step();
      chk_all("duck_6ticks", 9, 1, 2);
      repeat (6) step();
      chk_all("duck_wrap", 8, 0, 2);
      tick = 1'b0;
      isDuck = 1'b0;
      step();
      chk_all("duck_to_run", 4, 0, 1);

      // Death flash then hold, restart blocked while isDead, then restart.
      isDead = 1'b1;
      step();
      chk_all("flash_enter", 1, 0, 5);
      tick = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         step();
         chk_all($sformatf("flash_t%0d", k),
                 (k < 24 && ((k / 6) % 2 == 1)) ? 2 : 1, 0, (k == 24) ? 6 : 5);
      end
      repeat (3) step();
      chk_all("dead_hold", 1, 0, 6);
      tick = 1'b0;
      restart = 1'b1;
      step();
      chk_all("dead_restart_blocked", 1, 0, 6);
      isDead = 1'b0;
      step();
      chk_all("dead_restart", 0, 0, 0);
      restart = 1'b0;

      // Leaving FLASH needs restart; dropping isDead alone keeps flashing.
      step();
      chk_all("rerun", 4, 0, 1);
      isDead = 1'b1;
      step();
      tick = 1'b1;
      repeat (6) step();
      tick = 1'b0;
      isDead = 1'b0;
      step();
      chk_all("flash_no_restart", 2, 0, 5);
      restart = 1'b1;
      step();
      chk_all("flash_restart", 0, 0, 0);
      restart = 1'b0;

      // Reset in the middle of a flash.
      step();
      isDead = 1'b1;
      step();
      tick = 1'b1;
      repeat (8) step();
      rst = 1'b0;
      step();
      chk_all("flash_reset", 0, 0, 0);
      rst = 1'b1;
      tick = 1'b0;
      isDead = 1'b0;
      step();
      chk_all("after_flash_reset", 4, 0, 1);

      // Three-frame run, divide by one, no flash.
      do_reset();
      onGround = 1'b1;
      step();
      chk("p_run_enter.sel", 32'(p_sel), 32'd4);
      chk("p_run_enter.state", 32'(p_st), 32'd1);
      tick = 1'b1;
      step();
      chk("p_t1.sel", 32'(p_sel), 32'd5);
      chk("p_t1.frame", 32'(p_frm), 32'd1);
      step();
      chk("p_t2.sel", 32'(p_sel), 32'd6);
      chk("p_t2.frame", 32'(p_frm), 32'd2);
      step();
      chk("p_t3.sel", 32'(p_sel), 32'd4);
      chk("p_t3.frame", 32'(p_frm), 32'd0);
      tick = 1'b0;
      isDead = 1'b1;
      step();
      chk("p_dead.sel", 32'(p_sel), 32'd1);
      chk("p_dead.state", 32'(p_st), 32'd6);
      isDead = 1'b0;
      restart = 1'b1;
      step();
      chk("p_restart.state", 32'(p_st), 32'd0);
      chk("p_restart.sel", 32'(p_sel), 32'd0);
      restart = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
